// File: rtl/pong_game_ctrl.sv
// Pong game-sequencing controller.
// Decodes UART command bytes (start, pause, reset), keeps both players'
// scores from the core's miss pulses, and times the serve delay in VSync
// frame ticks. It tells the core when the ball is live, when to serve and
// in which direction. All outputs are registered.
module pong_game_ctrl #(
  parameter int         WIN_SCORE    = 9,
  parameter int         SERVE_FRAMES = 60,
  parameter logic [7:0] CMD_START    = 8'h53,
  parameter logic [7:0] CMD_PAUSE    = 8'h50,
  parameter logic [7:0] CMD_RESET    = 8'h52
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_VSync,
  input  logic       i_Miss_P1,
  input  logic       i_Miss_P2,
  output logic       o_Game_Active,
  output logic       o_Serve,
  output logic       o_Serve_Dir,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    PLAY       = 3'd2,
    PAUSED     = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN_S = 4'(WIN_SCORE);
  localparam logic [7:0] SRV_F = 8'(SERVE_FRAMES);

  state_t     state;
  state_t     saved;
  logic [7:0] cnt;
  logic       vsync_q;
  logic       tick;

  logic       cmd_start;
  logic       cmd_pause;
  logic       cmd_reset;

  // Outcome of the miss inputs while in PLAY, resolved before any pause
  // so a simultaneous pause saves the post-miss state.
  state_t     post;
  logic [3:0] p1_nxt;
  logic [3:0] p2_nxt;
  logic [1:0] win_nxt;
  logic       dir_nxt;

  assign cmd_start = i_RX_DV && (i_RX_Byte == CMD_START);
  assign cmd_pause = i_RX_DV && (i_RX_Byte == CMD_PAUSE);
  assign cmd_reset = i_RX_DV && (i_RX_Byte == CMD_RESET);

  // One-cycle frame tick on the rising edge of VSync.
  assign tick = i_VSync & ~vsync_q;

  assign o_State = state;

  // VSync history for edge detection.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) vsync_q <= 1'b0;
    else         vsync_q <= i_VSync;
  end

  // Resolve scoring for the current cycle's miss pulses.
  always_comb begin
    post    = PLAY;
    p1_nxt  = o_P1_Score;
    p2_nxt  = o_P2_Score;
    win_nxt = o_Winner;
    dir_nxt = o_Serve_Dir;
    if (i_Miss_P1 && i_Miss_P2) begin
      // Ambiguous double miss: nobody scores, re-serve the same way.
      post = SERVE_WAIT;
    end else if (i_Miss_P1) begin
      dir_nxt = 1'b0;
      if (o_P2_Score < WIN_S) p2_nxt = o_P2_Score + 4'd1;
      if (p2_nxt == WIN_S) begin
        post    = GAME_OVER;
        win_nxt = 2'd2;
      end else begin
        post = SERVE_WAIT;
      end
    end else if (i_Miss_P2) begin
      dir_nxt = 1'b1;
      if (o_P1_Score < WIN_S) p1_nxt = o_P1_Score + 4'd1;
      if (p1_nxt == WIN_S) begin
        post    = GAME_OVER;
        win_nxt = 2'd1;
      end else begin
        post = SERVE_WAIT;
      end
    end
  end

  // Game sequencing FSM with registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || cmd_reset) begin
      state         <= IDLE;
      saved         <= IDLE;
      cnt           <= 8'd0;
      o_P1_Score    <= 4'd0;
      o_P2_Score    <= 4'd0;
      o_Winner      <= 2'd0;
      o_Serve       <= 1'b0;
      o_Serve_Dir   <= 1'b0;
      o_Game_Active <= 1'b0;
    end else begin
      o_Serve <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            cnt         <= SRV_F;
            o_Serve_Dir <= 1'b1;
            state       <= SERVE_WAIT;
          end
        end

        SERVE_WAIT: begin
          // Pause takes priority so the counter stays frozen.
          if (cmd_pause) begin
            saved <= SERVE_WAIT;
            state <= PAUSED;
          end else if (tick) begin
            if (cnt > 8'd1) begin
              cnt <= cnt - 8'd1;
            end else begin
              cnt           <= 8'd0;
              o_Serve       <= 1'b1;
              o_Game_Active <= 1'b1;
              state         <= PLAY;
            end
          end
        end

        PLAY: begin
          o_P1_Score  <= p1_nxt;
          o_P2_Score  <= p2_nxt;
          o_Winner    <= win_nxt;
          o_Serve_Dir <= dir_nxt;
          if (post == SERVE_WAIT) cnt <= SRV_F;
          if (cmd_pause) begin
            saved         <= post;
            state         <= PAUSED;
            o_Game_Active <= 1'b0;
          end else begin
            state         <= post;
            o_Game_Active <= (post == PLAY);
          end
        end

        PAUSED: begin
          if (cmd_pause || cmd_start) begin
            state         <= saved;
            o_Game_Active <= (saved == PLAY);
          end
        end

        GAME_OVER: begin
          if (cmd_start) begin
            o_P1_Score  <= 4'd0;
            o_P2_Score  <= 4'd0;
            o_Winner    <= 2'd0;
            o_Serve_Dir <= 1'b1;
            cnt         <= SRV_F;
            state       <= SERVE_WAIT;
          end
        end

        default: begin
          state         <= IDLE;
          o_Game_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with SERVE_FRAMES=3 and WIN_SCORE=2.
// A table of one-cycle vectors drives the main game flow; hand-written
// sequences cover pause during serve, reset mid-serve and pause+miss.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       vsync;
  logic       miss1;
  logic       miss2;
  logic       game_active;
  logic       serve;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  pong_game_ctrl #(
    .WIN_SCORE   (2),
    .SERVE_FRAMES(3)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_RX_DV      (rx_dv),
    .i_RX_Byte    (rx_byte),
    .i_VSync      (vsync),
    .i_Miss_P1    (miss1),
    .i_Miss_P2    (miss2),
    .o_Game_Active(game_active),
    .o_Serve      (serve),
    .o_Serve_Dir  (serve_dir),
    .o_P1_Score   (p1_score),
    .o_P2_Score   (p2_score),
    .o_Winner     (winner),
    .o_State      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [7:0] byt;
    logic       vs;
    logic       m1;
    logic       m2;
    logic [2:0] st;
    logic       srv;
    logic       dir;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] win;
    logic       act;
  } vec_t;

  vec_t vecs[$];

  // Packed view of all outputs: {state, serve, dir, p1, p2, winner, active}
  function automatic logic [15:0] pack_out();
    return {state, serve, serve_dir, p1_score, p2_score, winner, game_active};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d srv=%0b dir=%0b p1=%0d p2=%0d win=%0d act=%0b, want st=%0d srv=%0b dir=%0b p1=%0d p2=%0d win=%0d act=%0b",
               name, got[15:13], got[12], got[11], got[10:7], got[6:3], got[2:1], got[0],
               exp[15:13], exp[12], exp[11], exp[10:7], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [7:0] b, input logic vs,
                       input logic m1, input logic m2);
    rx_dv = dv; rx_byte = b; vsync = vs; miss1 = m1; miss2 = m2;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input logic dv, input logic [7:0] b, input logic vs,
                     input logic m1, input logic m2, input logic [2:0] st,
                     input logic srv, input logic dir, input logic [3:0] p1,
                     input logic [3:0] p2, input logic [1:0] win, input logic act);
    vec_t v;
    v.dv = dv; v.byt = b; v.vs = vs; v.m1 = m1; v.m2 = m2;
    v.st = st; v.srv = srv; v.dir = dir; v.p1 = p1; v.p2 = p2; v.win = win; v.act = act;
    vecs.push_back(v);
  endtask

  // Three frame ticks from SERVE_WAIT with a fresh counter, then one PLAY cycle.
  task automatic add_serve(input logic dir, input logic [3:0] p1, input logic [3:0] p2);
    add(0, 8'h00, 1, 0, 0, 3'd1, 0, dir, p1, p2, 2'd0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd1, 0, dir, p1, p2, 2'd0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd1, 0, dir, p1, p2, 2'd0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd1, 0, dir, p1, p2, 2'd0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd2, 1, dir, p1, p2, 2'd0, 1);
    add(0, 8'h00, 0, 0, 0, 3'd2, 0, dir, p1, p2, 2'd0, 1);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic tick_once();
    vsync = 1'b1; cyc();
    vsync = 1'b0; cyc();
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b; cyc();
    rx_dv = 1'b0; rx_byte = 8'h00;
  endtask

  initial begin
    int serves;

    rst = 1'b1;
    idle_inputs();
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_state", pack_out(), 16'h0000);

    // Main flow vectors
    add(1, 8'h41, 0, 0, 0, 3'd0, 0, 0, 4'd0, 4'd0, 2'd0, 0);   // unknown byte ignored
    add(0, 8'h00, 1, 0, 0, 3'd0, 0, 0, 4'd0, 4'd0, 2'd0, 0);   // tick in IDLE ignored
    add(0, 8'h00, 0, 1, 0, 3'd0, 0, 0, 4'd0, 4'd0, 2'd0, 0);   // miss in IDLE ignored
    add(1, 8'h53, 0, 0, 0, 3'd1, 0, 1, 4'd0, 4'd0, 2'd0, 0);   // start
    add_serve(1'b1, 4'd0, 4'd0);
    add(0, 8'h00, 0, 1, 0, 3'd1, 0, 0, 4'd0, 4'd1, 2'd0, 0);   // P1 miss -> P2 scores
    add_serve(1'b0, 4'd0, 4'd1);
    add(0, 8'h00, 0, 1, 1, 3'd1, 0, 0, 4'd0, 4'd1, 2'd0, 0);   // double miss -> no score
    add_serve(1'b0, 4'd0, 4'd1);
    add(0, 8'h00, 0, 0, 1, 3'd1, 0, 1, 4'd1, 4'd1, 2'd0, 0);   // P2 miss -> P1 scores
    add_serve(1'b1, 4'd1, 4'd1);
    add(1, 8'h52, 0, 0, 0, 3'd0, 0, 0, 4'd0, 4'd0, 2'd0, 0);   // 'R' at 1:1 in PLAY
    add(0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 4'd0, 4'd0, 2'd0, 0);
    add(1, 8'h53, 0, 0, 0, 3'd1, 0, 1, 4'd0, 4'd0, 2'd0, 0);
    add_serve(1'b1, 4'd0, 4'd0);
    add(0, 8'h00, 0, 0, 1, 3'd1, 0, 1, 4'd1, 4'd0, 2'd0, 0);
    add_serve(1'b1, 4'd1, 4'd0);
    add(0, 8'h00, 0, 0, 1, 3'd4, 0, 1, 4'd2, 4'd0, 2'd1, 0);   // win at 2
    add(0, 8'h00, 0, 0, 1, 3'd4, 0, 1, 4'd2, 4'd0, 2'd1, 0);   // misses ignored
    add(0, 8'h00, 0, 1, 0, 3'd4, 0, 1, 4'd2, 4'd0, 2'd1, 0);
    add(0, 8'h00, 1, 0, 0, 3'd4, 0, 1, 4'd2, 4'd0, 2'd1, 0);   // tick ignored
    add(1, 8'h53, 0, 0, 0, 3'd1, 0, 1, 4'd0, 4'd0, 2'd0, 0);   // restart
    add_serve(1'b1, 4'd0, 4'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].dv, vecs[i].byt, vecs[i].vs, vecs[i].m1, vecs[i].m2);
      cyc();
      chk($sformatf("vec%0d", i), pack_out(),
          {vecs[i].st, vecs[i].srv, vecs[i].dir, vecs[i].p1, vecs[i].p2, vecs[i].win, vecs[i].act});
    end
    idle_inputs();

    // Pause in SERVE_WAIT with counter = 2: ticks while paused do nothing.
    do_reset();
    send(8'h53);
    tick_once();                                  // counter 3 -> 2
    send(8'h50);
    chk("pause_sw_state", pack_out(), {3'd3, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0});
    serves = 0;
    for (int k = 0; k < 5; k++) begin
      vsync = 1'b1; cyc(); serves += int'(serve);
      vsync = 1'b0; cyc(); serves += int'(serve);
    end
    chk1("pause_no_serve", serves == 0, 1'b1);
    chk("paused_hold", pack_out(), {3'd3, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0});
    send(8'h50);
    chk("resume_sw", pack_out(), {3'd1, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0});
    vsync = 1'b1; cyc();                          // counter 2 -> 1
    chk1("resume_tick1_no_serve", serve, 1'b0);
    vsync = 1'b0; cyc();
    vsync = 1'b1; cyc();                          // counter 1 -> serve
    chk("resume_serve", pack_out(), {3'd2, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0, 1'b1});
    vsync = 1'b0; cyc();
    chk("resume_serve_single", pack_out(), {3'd2, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b1});

    // Pause in the same cycle as a miss: score first, resume to SERVE_WAIT.
    rx_dv = 1'b1; rx_byte = 8'h50; miss2 = 1'b1; cyc();
    idle_inputs();
    chk("pause_miss", pack_out(), {3'd3, 1'b0, 1'b1, 4'd1, 4'd0, 2'd0, 1'b0});
    send(8'h53);
    chk("pause_miss_resume", pack_out(), {3'd1, 1'b0, 1'b1, 4'd1, 4'd0, 2'd0, 1'b0});

    // Synchronous reset mid SERVE_WAIT, coinciding with the final tick.
    do_reset();
    send(8'h53);
    tick_once();
    tick_once();                                  // counter now 1
    vsync = 1'b1; rst = 1'b1; cyc();
    rst = 1'b0; vsync = 1'b0;
    chk("rst_mid_sw", pack_out(), 16'h0000);
    serves = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(); serves += int'(serve);
    end
    chk1("rst_no_serve", serves == 0, 1'b1);
    chk("rst_idle_hold", pack_out(), 16'h0000);

    // 'R' wins over a simultaneous final tick in SERVE_WAIT.
    send(8'h53);
    tick_once();
    tick_once();
    rx_dv = 1'b1; rx_byte = 8'h52; vsync = 1'b1; cyc();
    idle_inputs();
    chk("cmd_r_over_tick", pack_out(), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
